shift_sequencer: RTL and testbench

- Command-driven controller sitting directly upstream of the 4-bit circular shift register; it generates that register's S, D and OE inputs.
- Accepts load, rotate-by-N and output-enable commands over a valid/ready handshake and expands each rotate into N single-step S pulses.
- Keeps a shadow copy of the register contents so software and checkers can read the expected value without sampling the tri-stated bus.

---
 rtl/shift_sequencer.sv | 171 +++++++++++++++++
 tb/tb_shift_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Command-driven controller for a WIDTH-bit circular shift
//            register. Accepts LOAD / ROTL / ROTR / SETOE commands over a
//            valid/ready handshake, expands each rotate into single-step
//            S pulses and keeps a shadow copy of the register contents.
// Ports    : CLK, RST            - clock (rising edge), sync active-high reset
//            CMD_VALID/CMD_READY - command handshake
//            CMD_OP              - 00 LOAD, 01 ROTL, 10 ROTR, 11 SETOE
//            CMD_COUNT           - rotate amount (taken mod WIDTH)
//            CMD_DATA            - load value / bit 0 = new OE
//            S, D, OE            - register mode, load bus, output suppress
//            DONE                - one-cycle completion pulse
//            SHADOW/SHADOW_VALID - expected register contents and validity
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH    = 4,
    parameter int COUNT_W  = 3,
    parameter int SHORTEST = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [1:0]         CMD_OP,
    input  logic [COUNT_W-1:0] CMD_COUNT,
    input  logic [WIDTH-1:0]   CMD_DATA,
    output logic [1:0]         S,
    output logic [WIDTH-1:0]   D,
    output logic               OE,
    output logic               DONE,
    output logic [WIDTH-1:0]   SHADOW,
    output logic               SHADOW_VALID
);

    // Rotate amounts live in the low log2(WIDTH) bits of CMD_COUNT.
    localparam int              c_KW   = $clog2(WIDTH);
    localparam logic [c_KW:0]   c_HALF = (c_KW+1)'(WIDTH/2);
    localparam logic [c_KW-1:0] c_ONE  = c_KW'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;

    localparam logic [1:0] c_OP_LOAD  = 2'b00;
    localparam logic [1:0] c_OP_SETOE = 2'b11;

    localparam logic [1:0] c_S_HOLD  = 2'b00;
    localparam logic [1:0] c_S_LEFT  = 2'b01;
    localparam logic [1:0] c_S_LOAD  = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       r_s;
    logic [WIDTH-1:0] r_d;
    logic             r_oe;
    logic             r_done;
    logic [WIDTH-1:0] r_shadow;
    logic             r_shadow_valid;
    logic [c_KW-1:0]  r_remain;

    logic [c_KW-1:0]  w_k_raw;
    logic             w_flip;
    logic [c_KW-1:0]  w_k;
    logic [1:0]       w_dir;
    logic [WIDTH-1:0] w_rotl;
    logic [WIDTH-1:0] w_rotr;
    logic             w_ready;
    logic             w_accept;
    logic             w_unused_count;

    // Bits of CMD_COUNT above log2(WIDTH) do not affect a circular rotate.
    assign w_unused_count = ^CMD_COUNT;

    assign w_k_raw = CMD_COUNT[c_KW-1:0];
    // Going the long way round by k equals going the other way by WIDTH-k.
    assign w_flip  = (SHORTEST != 0) && ({1'b0, w_k_raw} > c_HALF);
    // WIDTH is a power of two, so WIDTH-k is the two's complement of k.
    assign w_k     = w_flip ? (~w_k_raw + c_ONE) : w_k_raw;
    // ROTL/ROTR opcodes coincide with the left/right S codes; swapping the
    // two bits reverses direction.
    assign w_dir   = w_flip ? {CMD_OP[0], CMD_OP[1]} : CMD_OP;

    assign w_rotl  = {r_shadow[WIDTH-2:0], r_shadow[WIDTH-1]};
    assign w_rotr  = {r_shadow[0], r_shadow[WIDTH-1:1]};

    assign w_ready  = (r_state == c_ST_IDLE) && !RST;
    assign w_accept = CMD_VALID && w_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= c_ST_IDLE;
            r_s            <= c_S_HOLD;
            r_d            <= '0;
            r_oe           <= 1'b1;
            r_done         <= 1'b0;
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
            r_remain       <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_s    <= c_S_HOLD;
                    r_d    <= '0;
                    r_done <= 1'b0;
                    if (w_accept) begin
                        case (CMD_OP)
                            c_OP_LOAD: begin
                                r_state <= c_ST_LOAD;
                                r_s     <= c_S_LOAD;
                                r_d     <= CMD_DATA;
                            end
                            c_OP_SETOE: begin
                                r_oe   <= CMD_DATA[0];
                                r_done <= 1'b1;
                            end
                            default: begin
                                if (w_k == '0) begin
                                    // Whole-turn rotate: completes at once.
                                    r_done <= 1'b1;
                                end else begin
                                    r_state  <= c_ST_SHIFT;
                                    r_s      <= w_dir;
                                    r_remain <= w_k;
                                end
                            end
                        endcase
                    end
                end
                c_ST_LOAD: begin
                    r_shadow       <= r_d;
                    r_shadow_valid <= 1'b1;
                    r_state        <= c_ST_IDLE;
                    r_s            <= c_S_HOLD;
                    r_d            <= '0;
                    r_done         <= 1'b1;
                end
                c_ST_SHIFT: begin
                    // Shadow tracks the register one step per S pulse.
                    r_shadow <= (r_s == c_S_LEFT) ? w_rotl : w_rotr;
                    r_done   <= 1'b0;
                    if (r_remain == c_ONE) begin
                        r_state <= c_ST_IDLE;
                        r_s     <= c_S_HOLD;
                        r_done  <= 1'b1;
                    end else begin
                        r_remain <= r_remain - c_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_s     <= c_S_HOLD;
                    r_d     <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign CMD_READY    = w_ready;
    assign S            = r_s;
    assign D            = r_d;
    assign OE           = r_oe;
    assign DONE         = r_done;
    assign SHADOW       = r_shadow;
    assign SHADOW_VALID = r_shadow_valid;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer. Two instances share
//            the command bus (SHORTEST=1 and SHORTEST=0); sel routes
//            CMD_VALID and the observed outputs to one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CMD_VALID;
    logic [1:0] CMD_OP;
    logic [2:0] CMD_COUNT;
    logic [3:0] CMD_DATA;
    logic       sel;

    logic       rdy1, oe1, done1, sv1, rdy0, oe0, done0, sv0;
    logic [1:0] s1, s0;
    logic [3:0] d1, d0, sh1, sh0;

    logic       valid1, valid0;
    logic       rdy, oe, done, sv;
    logic [1:0] s;
    logic [3:0] d, sh;

    assign valid1 = CMD_VALID & sel;
    assign valid0 = CMD_VALID & ~sel;
    assign rdy  = sel ? rdy1  : rdy0;
    assign oe   = sel ? oe1   : oe0;
    assign done = sel ? done1 : done0;
    assign sv   = sel ? sv1   : sv0;
    assign s    = sel ? s1    : s0;
    assign d    = sel ? d1    : d0;
    assign sh   = sel ? sh1   : sh0;

    shift_sequencer #(.WIDTH(4), .COUNT_W(3), .SHORTEST(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .CMD_VALID(valid1), .CMD_READY(rdy1),
        .CMD_OP(CMD_OP), .CMD_COUNT(CMD_COUNT), .CMD_DATA(CMD_DATA),
        .S(s1), .D(d1), .OE(oe1), .DONE(done1), .SHADOW(sh1), .SHADOW_VALID(sv1)
    );

    shift_sequencer #(.WIDTH(4), .COUNT_W(3), .SHORTEST(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .CMD_VALID(valid0), .CMD_READY(rdy0),
        .CMD_OP(CMD_OP), .CMD_COUNT(CMD_COUNT), .CMD_DATA(CMD_DATA),
        .S(s0), .D(d0), .OE(oe0), .DONE(done0), .SHADOW(sh0), .SHADOW_VALID(sv0)
    );

    always #5 CLK = ~CLK;

    // Model of the downstream 4-bit circular register, driven by S/D.
    logic [3:0] mreg = 4'h0;
    always @(posedge CLK) begin
        case (s)
            2'b11:   mreg <= d;
            2'b01:   mreg <= {mreg[2:0], mreg[3]};
            2'b10:   mreg <= {mreg[0], mreg[3:1]};
            default: mreg <= mreg;
        endcase
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rotl_n(input logic [3:0] x, input int n);
        int v;
        v = int'(x);
        v = ((v << n) | (v >> (4 - n))) & 15;
        return v[3:0];
    endfunction

    // Results of the last do_cmd call.
    int         t_ns, t_ncyc;
    logic [1:0] t_sfirst;
    logic       t_sbad, t_dbad, t_timeout;

    // Issue one command from a negedge and observe until its DONE cycle.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
        int guard;
        t_ns = 0; t_ncyc = 0; t_sfirst = 2'b00;
        t_sbad = 1'b0; t_dbad = 1'b0; t_timeout = 1'b0;
        CMD_OP = op; CMD_COUNT = cnt; CMD_DATA = data; CMD_VALID = 1'b1;
        guard = 0;
        while (rdy !== 1'b1 && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (rdy !== 1'b1) begin
            t_timeout = 1'b1;
            CMD_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        for (int i = 0; i < 20; i++) begin
            t_ncyc++;
            if (s !== 2'b00) begin
                if (t_ns == 0) t_sfirst = s;
                else if (s !== t_sfirst) t_sbad = 1'b1;
                t_ns++;
            end
            if (s === 2'b11 ? (d !== data) : (d !== 4'h0)) t_dbad = 1'b1;
            if (done === 1'b1) return;
            @(negedge CLK);
        end
        t_timeout = 1'b1;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] cnt;
        logic [3:0] data;
        logic       sel;
        int         ens;
        logic [1:0] es;
        logic [3:0] esh;
        logic       eoe;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //           op     cnt   data     sel   ns  S      shadow   OE
        tbl[0] = '{2'b00, 3'd0, 4'b1001, 1'b1, 1, 2'b11, 4'b1001, 1'b1};
        tbl[1] = '{2'b01, 3'd3, 4'b0000, 1'b1, 1, 2'b10, 4'b1100, 1'b1};
        tbl[2] = '{2'b00, 3'd0, 4'b1001, 1'b0, 1, 2'b11, 4'b1001, 1'b1};
        tbl[3] = '{2'b01, 3'd3, 4'b0000, 1'b0, 3, 2'b01, 4'b1100, 1'b1};
        tbl[4] = '{2'b00, 3'd0, 4'b1001, 1'b1, 1, 2'b11, 4'b1001, 1'b1};
        tbl[5] = '{2'b10, 3'd6, 4'b0000, 1'b1, 2, 2'b10, 4'b0110, 1'b1};
        tbl[6] = '{2'b01, 3'd4, 4'b0000, 1'b1, 0, 2'b00, 4'b0110, 1'b1};
        tbl[7] = '{2'b11, 3'd0, 4'b0000, 1'b1, 0, 2'b00, 4'b0110, 1'b0};
        tbl[8] = '{2'b01, 3'd5, 4'b0000, 1'b1, 1, 2'b01, 4'b1100, 1'b0};
        tbl[9] = '{2'b11, 3'd0, 4'b0001, 1'b1, 0, 2'b00, 4'b1100, 1'b1};

        sel = 1'b1; RST = 1'b1; CMD_VALID = 1'b0;
        CMD_OP = 2'b00; CMD_COUNT = 3'd0; CMD_DATA = 4'h0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_s", s, 2'b00);
        chk("rst_d", d, 4'h0);
        chk("rst_oe", oe, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_shadow", sh, 4'h0);
        chk("rst_sv", sv, 1'b0);
        chk("rst_ready_low", rdy, 1'b0);
        RST = 1'b0;
        #1;
        chk("rst_ready_high", rdy, 1'b1);
        @(negedge CLK);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            sel = tbl[i].sel;
            do_cmd(tbl[i].op, tbl[i].cnt, tbl[i].data);
            chk($sformatf("tbl%0d_timeout", i), t_timeout, 1'b0);
            chk($sformatf("tbl%0d_npulse", i), t_ns, tbl[i].ens);
            chk($sformatf("tbl%0d_sval", i), t_sfirst, tbl[i].es);
            chk($sformatf("tbl%0d_steady", i), {t_sbad, t_dbad}, 2'b00);
            chk($sformatf("tbl%0d_ncyc", i), t_ncyc, tbl[i].ens + 1);
            chk($sformatf("tbl%0d_shadow", i), sh, tbl[i].esh);
            chk($sformatf("tbl%0d_sv", i), sv, 1'b1);
            chk($sformatf("tbl%0d_oe", i), oe, tbl[i].eoe);
            chk($sformatf("tbl%0d_ready", i), rdy, 1'b1);
        end

        // Back-to-back: SETOE 0, then LOAD 0101 accepted on the DONE edge
        sel = 1'b1;
        CMD_OP = 2'b11; CMD_DATA = 4'b0000; CMD_COUNT = 3'd0; CMD_VALID = 1'b1;
        @(posedge CLK); @(negedge CLK);
        chk("b2b_setoe_done", done, 1'b1);
        chk("b2b_setoe_oe", oe, 1'b0);
        CMD_OP = 2'b00; CMD_DATA = 4'b0101;
        @(posedge CLK); @(negedge CLK);
        chk("b2b_load_s", s, 2'b11);
        chk("b2b_load_d", d, 4'b0101);
        chk("b2b_load_ready", rdy, 1'b0);
        CMD_VALID = 1'b0;
        @(negedge CLK);
        chk("b2b_load_done", done, 1'b1);
        chk("b2b_load_shadow", sh, 4'b0101);

        // Reset during cycle 2 of ROTR 3 on the SHORTEST=0 instance
        sel = 1'b0;
        do_cmd(2'b11, 3'd0, 4'b0000);
        chk("rmid_pre_oe", oe, 1'b0);
        CMD_OP = 2'b10; CMD_COUNT = 3'd3; CMD_DATA = 4'h0; CMD_VALID = 1'b1;
        @(posedge CLK); @(negedge CLK);
        CMD_VALID = 1'b0;
        chk("rmid_c1_s", s, 2'b10);
        @(negedge CLK);
        chk("rmid_c2_s", s, 2'b10);
        RST = 1'b1;
        @(negedge CLK);
        chk("rmid_s", s, 2'b00);
        chk("rmid_done", done, 1'b0);
        chk("rmid_oe", oe, 1'b1);
        chk("rmid_sv", sv, 1'b0);
        chk("rmid_ready_low", rdy, 1'b0);
        RST = 1'b0;
        #1;
        chk("rmid_ready_high", rdy, 1'b1);
        @(negedge CLK);
        chk("rmid_after_done", done, 1'b0);
        chk("rmid_after_s", s, 2'b00);

        // Random commands against an arithmetic reference model
        for (int pass = 0; pass < 2; pass++) begin
            logic [3:0] msh;
            logic       moe;
            logic [1:0] op;
            logic [2:0] cnt;
            logic [3:0] data;
            int         k, ens;
            logic [1:0] es;
            sel = (pass == 0);
            msh = 4'h0;
            moe = oe;
            for (int n = 0; n < 60; n++) begin
                op   = (n == 0) ? 2'b00 : 2'($urandom_range(0, 3));
                cnt  = 3'($urandom_range(0, 7));
                data = 4'($urandom_range(0, 15));
                ens  = 0;
                es   = 2'b00;
                case (op)
                    2'b00: begin
                        msh = data; ens = 1; es = 2'b11;
                    end
                    2'b11: moe = data[0];
                    default: begin
                        k = int'(cnt) % 4;
                        msh = (op == 2'b01) ? rotl_n(msh, k) : rotl_n(msh, (4 - k) % 4);
                        ens = k;
                        es  = op;
                        if (sel && k > 2) begin
                            ens = 4 - k;
                            es  = (op == 2'b01) ? 2'b10 : 2'b01;
                        end
                        if (ens == 0) es = 2'b00;
                    end
                endcase
                do_cmd(op, cnt, data);
                chk("rnd_timeout", t_timeout, 1'b0);
                chk("rnd_npulse", t_ns, ens);
                chk("rnd_sval", t_sfirst, es);
                chk("rnd_steady", {t_sbad, t_dbad}, 2'b00);
                chk("rnd_ncyc", t_ncyc, ens + 1);
                chk("rnd_shadow", sh, msh);
                chk("rnd_regmodel", sh, mreg);
                chk("rnd_sv", sv, 1'b1);
                chk("rnd_oe", oe, moe);
                repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
